// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that lets a CPU (rq0) and a DMA loader (rq1)
// share one fixed-latency memory port. Only one transaction is in flight at a
// time: IDLE picks a winner and latches its request, ACCESS drives the memory
// for LAT cycles and captures the read data in its last cycle, and RESP returns
// a one-cycle ack plus the captured data to the winner.
// All outputs come straight from flops, so a reset drops them immediately.
module mem_arbiter #(
  parameter int N   = 64,  // data/address width in bits
  parameter int LAT = 1    // memory read latency in cycles, legal range 1..4
) (
  input  logic         clk,
  input  logic         reset,         // asynchronous, active-low
  // requester 0 (CPU)
  input  logic         rq0_req,
  input  logic [1:0]   rq0_memwrite,
  input  logic         rq0_dword,
  input  logic [N-1:0] rq0_adr,
  input  logic [N-1:0] rq0_wdata,
  output logic         rq0_ack,
  output logic [N-1:0] rq0_rdata,
  // requester 1 (DMA loader)
  input  logic         rq1_req,
  input  logic [1:0]   rq1_memwrite,
  input  logic         rq1_dword,
  input  logic [N-1:0] rq1_adr,
  input  logic [N-1:0] rq1_wdata,
  output logic         rq1_ack,
  output logic [N-1:0] rq1_rdata,
  // memory side
  output logic         mem_en,
  output logic [N-1:0] mem_adr,
  output logic [N-1:0] mem_wdata,
  output logic [1:0]   mem_memwrite,
  output logic         mem_dword,
  input  logic [N-1:0] mem_rdata,
  // status
  output logic         owner,
  output logic         busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // The counter is loaded on grant and counts down to zero across ACCESS.
  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  // control state
  logic [1:0]   state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         ptr_q, ptr_d;      // requester served last
  logic         owner_q, owner_d;

  // latched transaction and captured read data
  logic [1:0]   memwrite_q, memwrite_d;
  logic         dword_q, dword_d;
  logic [N-1:0] adr_q, adr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] rdata_q, rdata_d;

  // registered outputs
  logic         mem_en_q, mem_en_d;
  logic [1:0]   mem_memwrite_q, mem_memwrite_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic         busy_q, busy_d;

  // arbitration helpers
  logic         any_req_s;
  logic         win_s;

  // Round-robin choice: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_req_s = rq0_req | rq1_req;
    if (rq0_req && rq1_req) begin
      win_s = ~ptr_q;
    end else if (rq1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state logic: grant and latch in IDLE, count down in ACCESS, one RESP cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    memwrite_d = memwrite_q;
    dword_d    = dword_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_INIT;
          ptr_d   = win_s;
          owner_d = win_s;
          if (win_s) begin
            memwrite_d = rq1_memwrite;
            dword_d    = rq1_dword;
            adr_d      = rq1_adr;
            wdata_d    = rq1_wdata;
          end else begin
            memwrite_d = rq0_memwrite;
            dword_d    = rq0_dword;
            adr_d      = rq0_adr;
            wdata_d    = rq0_wdata;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 2'd0) begin
          rdata_d = mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    mem_en_d = (state_d == ST_ACCESS);
    // The write class is presented only in the first ACCESS cycle.
    if ((state_q == ST_IDLE) && (state_d == ST_ACCESS)) begin
      mem_memwrite_d = memwrite_d;
    end else begin
      mem_memwrite_d = 2'b00;
    end
    ack0_d = (state_d == ST_RESP) && (owner_d == 1'b0);
    ack1_d = (state_d == ST_RESP) && (owner_d == 1'b1);
    busy_d = (state_d != ST_IDLE);
  end

  // Control registers; after reset the CPU wins the first tie (ptr=1).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      ptr_q   <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Latched request fields and captured read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memwrite_q <= 2'b00;
      dword_q    <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      memwrite_q <= memwrite_d;
      dword_q    <= dword_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Output registers; reset clears strobes and acks at once, aborting any access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en_q       <= 1'b0;
      mem_memwrite_q <= 2'b00;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      mem_en_q       <= mem_en_d;
      mem_memwrite_q <= mem_memwrite_d;
      ack0_q         <= ack0_d;
      ack1_q         <= ack1_d;
      busy_q         <= busy_d;
    end
  end

  assign rq0_ack      = ack0_q;
  assign rq1_ack      = ack1_q;
  assign rq0_rdata    = rdata_q;
  assign rq1_rdata    = rdata_q;
  assign mem_en       = mem_en_q;
  assign mem_memwrite = mem_memwrite_q;
  assign mem_adr      = adr_q;
  assign mem_wdata    = wdata_q;
  assign mem_dword    = dword_q;
  assign owner        = owner_q;
  assign busy         = busy_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 64, data/address width in bits.
REQ-002 Parameter LAT, default 1, memory read latency in cycles; legal range 1..4.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rqK_req  input  1  request from requester K (K=0 CPU, K=1 DMA loader); held high until rqK_ack.
REQ-006 rqK_memwrite  input  2  write byte-enable class (00 = read); held stable while rqK_req is high.
REQ-007 rqK_dword  input  1  doubleword access flag; held stable while rqK_req is high.
REQ-008 rqK_adr  input  N  byte address; held stable while rqK_req is high.
REQ-009 rqK_wdata  input  N  write data; held stable while rqK_req is high.
REQ-010 rqK_ack  output  1  one-cycle completion pulse to requester K.
REQ-011 rqK_rdata  output  N  read data, valid only in the rqK_ack cycle.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_adr, mem_wdata  output  N each  address and write data to memory.
REQ-014 mem_memwrite  output  2  memory write class; mem_dword  output  1  doubleword flag.
REQ-015 mem_rdata  input  N  memory read data, valid LAT cycles after the first mem_en cycle.
REQ-016 owner  output  1  index of the requester latched for the current or last transaction.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP.
REQ-019 IDLE with no request: stay in IDLE; mem_en=0, mem_memwrite=00.
REQ-020 IDLE with at least one request: latch the winner's memwrite/dword/adr/wdata, set owner, go to ACCESS, load cnt=LAT-1.
REQ-021 Arbitration is round-robin: a single requester wins; with both requesting, the winner is the requester other than the last one served (ptr); ptr updates when a grant is latched.
REQ-022 ACCESS: mem_en=1; mem_adr/mem_wdata/mem_dword come from the latched request; mem_memwrite = latched value in the first ACCESS cycle only, 00 in later cycles.
REQ-023 ACCESS: decrement cnt each cycle; when cnt==0, capture mem_rdata into rdata_q and go to RESP.
REQ-024 ACCESS lasts exactly LAT cycles.
REQ-025 RESP: rq[owner]_ack=1 for one cycle; go to IDLE.
REQ-026 RESP: other requester's ack=0; mem_en=0.
REQ-027 Latency: request sampled in IDLE at cycle t -> ack at cycle t+LAT+1; next grant no earlier than t+LAT+2.
REQ-028 rq0_rdata and rq1_rdata both drive rdata_q; for write transactions, rdata_q holds the value read in the last ACCESS cycle (don't-care to the requester).
REQ-029 Outside ACCESS, mem_adr/mem_wdata/mem_dword hold the last latched values.
REQ-030 A request arriving during ACCESS/RESP waits; it is evaluated in the next IDLE cycle.
REQ-031 A requester dropping req before its ack (protocol violation): the transaction still completes and the ack is still issued.
REQ-032 A request from the non-owner never alters the latched transaction.

Reset
REQ-033 reset low asynchronously forces IDLE, cnt=0, ptr=1 (CPU wins first tie), owner=0, rdata_q=0.
REQ-034 While reset is low: all acks=0, mem_en=0, mem_memwrite=00, mem_adr=0, mem_wdata=0, mem_dword=0, busy=0.
REQ-035 Reset asserted mid-ACCESS or mid-RESP aborts the transaction with no ack, and writes stop immediately; after release, held requests are re-arbitrated from IDLE.

Verification
REQ-036 LAT=1: rq0 read adr=0x40, mem_rdata=0x1122334455667788 -> mem_en one cycle; rq0_ack one cycle later with rq0_rdata=0x1122334455667788; total 2 cycles from request sample.
REQ-037 Both requesters assert in the same cycle after reset, each held until acked -> grant order rq0, rq1, rq0, rq1; owner toggles 0,1,0,1.
REQ-038 LAT=3: rq1 write memwrite=01, adr=0x80, wdata=0xDEAD -> mem_memwrite=01 in the first ACCESS cycle only; mem_en 3 cycles; rq1_ack at request-sample+4.
REQ-039 reset pulsed low in the second ACCESS cycle (LAT=3) -> mem_en and busy drop the same cycle, no ack; after release a still-held request restarts and completes normally.
REQ-040 rq1 requests while rq0 is in ACCESS -> rq1 is granted in the IDLE cycle after rq0_ack; the latched adr is unaffected during rq0's transaction.
